cmp_sched: RTL and testbench

//  Round-robin scheduler sharing one cmp_sub comparator among NUM_REQ strategy requesters.

---
 rtl/cmp_sched.sv | 86 ++++++++
 tb/tb_cmp_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one comparator among NUM_REQ requesters.
// Latency: transfer to rsp pulse is CMP_LAT+2 cycles, one compare issued per cycle.
// Backpressure: req_ready is the one-hot grant; responses cannot be stalled.
module cmp_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CMP_LAT    = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cfg_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_hi,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lo,
    output logic [DATA_WIDTH-1:0]         cmp_value_hi,
    output logic [DATA_WIDTH-1:0]         cmp_value_lo,
    input  logic                          cmp_cond_true,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ-1:0]            rsp_true,
    output logic                          busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] idx;
    } tag_t;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic          found;
    logic          xfer;

    // Entry 0 is the issue tag; entry CMP_LAT lines up with cmp_cond_true.
    tag_t tag_pipe [CMP_LAT+1];

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign xfer      = found && cfg_enable && reset_n;
    assign req_ready = xfer ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            cmp_value_hi <= '0;
            cmp_value_lo <= '0;
            rsp_valid    <= '0;
            rsp_true     <= '0;
            for (int k = 0; k <= CMP_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            if (xfer) begin
                rr_ptr       <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                cmp_value_hi <= req_hi[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                cmp_value_lo <= req_lo[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            end
            tag_pipe[0] <= tag_t'{v: xfer, idx: winner};
            for (int k = 1; k <= CMP_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            rsp_valid <= tag_pipe[CMP_LAT].v ? (NUM_REQ'(1) << tag_pipe[CMP_LAT].idx) : '0;
            rsp_true  <= (tag_pipe[CMP_LAT].v && cmp_cond_true)
                       ? (NUM_REQ'(1) << tag_pipe[CMP_LAT].idx) : '0;
        end
    end

    // Busy covers issued-but-unanswered compares, not the response register.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= CMP_LAT; k++) begin
            busy = busy | tag_pipe[k].v;
        end
    end

endmodule

// File: tb/tb_cmp_sched.sv
// Randomized scoreboard bench for cmp_sched with a behavioural comparator of latency LAT.
module tb_cmp_sched;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cfg_enable;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_hi;
    logic [N*DW-1:0]   req_lo;
    logic [DW-1:0]     cmp_value_hi;
    logic [DW-1:0]     cmp_value_lo;
    logic              cmp_cond_true;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_true;
    logic              busy;

    cmp_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .CMP_LAT(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_enable    (cfg_enable),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_hi        (req_hi),
        .req_lo        (req_lo),
        .cmp_value_hi  (cmp_value_hi),
        .cmp_value_lo  (cmp_value_lo),
        .cmp_cond_true (cmp_cond_true),
        .rsp_valid     (rsp_valid),
        .rsp_true      (rsp_true),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: strict unsigned greater-than, LAT cycles of delay.
    logic [LAT-1:0] cmp_sh;
    always @(posedge clk) cmp_sh <= (cmp_sh << 1) | LAT'(cmp_value_hi > cmp_value_lo);
    assign cmp_cond_true = cmp_sh[LAT-1];

    typedef struct {
        int idx;
        bit res;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ptr = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic en, input int p);
        if (!en) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Request side: arbitration reference and expected-response generation.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_true", 64'(rsp_true), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_cmp_hi", 64'(cmp_value_hi), 64'd0);
            chk("rst_cmp_lo", 64'(cmp_value_lo), 64'd0);
            q.delete();
            ptr = 0;
        end else begin
            int w;
            logic [N-1:0] exp_rdy;
            exp_t e;
            w = pick(req_valid, cfg_enable, ptr);
            exp_rdy = (w < 0) ? '0 : (N'(1) << w);
            chk("grant", 64'(req_ready), 64'(exp_rdy));
            if (w >= 0) begin
                e.idx = w;
                e.res = (req_hi[w*DW +: DW] > req_lo[w*DW +: DW]);
                e.due = cyc + 2 + LAT;
                q.push_back(e);
                ptr = (w + 1) % N;
            end
        end
    end

    // Response side: pops the scoreboard whenever a result appears or one is overdue.
    always @(negedge clk) begin
        if (reset_n) begin
            bit exp_busy;
            exp_t e;
            exp_busy = 1'b0;
            foreach (q[i]) begin
                if (cyc < q[i].due && cyc >= q[i].due - LAT - 1) exp_busy = 1'b1;
            end
            chk("busy", 64'(busy), 64'(exp_busy));
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e.idx));
                    chk("rsp_true", 64'(rsp_true), e.res ? 64'(N'(1) << e.idx) : 64'd0);
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else begin
                chk("rsp_true_idle", 64'(rsp_true), 64'd0);
                if (q.size() != 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    chk("rsp_missing", 64'(rsp_valid), 64'(N'(1) << e.idx));
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return DW'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic step(input logic [N-1:0] v, input logic en);
        @(posedge clk);
        #1;
        req_valid  = v;
        cfg_enable = en;
        for (int i = 0; i < N; i++) begin
            req_hi[i*DW +: DW] = rand_op();
            req_lo[i*DW +: DW] = rand_op();
        end
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
        req_hi[i*DW +: DW] = hi;
        req_lo[i*DW +: DW] = lo;
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_enable = 1'b0;
        req_valid  = '0;
        req_hi     = '0;
        req_lo     = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single compare from requester 2, then idle.
        step(4'b0100, 1'b1);
        set_op(2, 32'd10, 32'd3);
        repeat (5) step(4'b0000, 1'b1);

        // Unsigned boundaries: equal all-ones, then MSB set against 1.
        step(4'b0001, 1'b1);
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(4'b0001, 1'b1);
        set_op(0, 32'h8000_0000, 32'h0000_0001);
        step(4'b0001, 1'b1);
        set_op(0, 32'h0000_0001, 32'h8000_0000);

        // Back-to-back requester 1 then requester 3.
        step(4'b0010, 1'b1);
        step(4'b1000, 1'b1);
        repeat (6) step(4'b0000, 1'b1);

        // All requesters continuously valid.
        repeat (8) step(4'b1111, 1'b1);
        repeat (6) step(4'b0000, 1'b1);

        // Enable dropped with compares in flight, then resumed.
        repeat (2) step(4'b1111, 1'b1);
        repeat (7) step(4'b1111, 1'b0);
        repeat (3) step(4'b1111, 1'b1);

        // Random traffic with occasional enable drops.
        for (int n = 0; n < 400; n++) begin
            step(N'($urandom), ($urandom_range(0, 7) != 0));
        end

        // Reset pulse with three compares in flight.
        repeat (3) step(4'b1111, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) step(4'b1111, 1'b1);

        // Lone requester is granted every cycle.
        repeat (6) step(4'b0010, 1'b1);

        repeat (LAT + 6) step(4'b0000, 1'b1);
        chk("drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
